// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline register for the multi-issue core.
//
// Captures NUM_CH retiring write-back channels plus one HI/LO write and one LLbit write.
// Honours the shared stall/flush protocol and drops r0 writes. When two channels in the
// same beat write the same register, only the youngest (highest-index) write is kept.
// Also counts retired instructions and inserted bubbles.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stall              per-stage stall vector; bit STAGE_IDX is ours, STAGE_IDX+1 is WB's
//   flush              exception flush; clears the payload
//   mem_*              MEM-stage payload (channel i at [i*W +: W] in packed vectors)
//   wb_*               registered, conflict-resolved payload towards the WB writers
//   retire_cnt         instructions retired through this stage (wraps)
//   bubble_cnt         bubbles inserted by this stage (saturates)
module mem_wb_pipe #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned STALL_W   = 6,
   parameter int unsigned STAGE_IDX = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [STALL_W-1:0]       stall,
   input  logic                     flush,
   input  logic [NUM_CH-1:0]        mem_valid,
   input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
   input  logic [NUM_CH-1:0]        mem_wreg,
   input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
   input  logic                     mem_whilo,
   input  logic [DATA_W-1:0]        mem_hi,
   input  logic [DATA_W-1:0]        mem_lo,
   input  logic                     mem_llbit_we,
   input  logic                     mem_llbit_value,
   output logic [NUM_CH-1:0]        wb_valid,
   output logic [NUM_CH*ADDR_W-1:0] wb_wd,
   output logic [NUM_CH-1:0]        wb_wreg,
   output logic [NUM_CH*DATA_W-1:0] wb_wdata,
   output logic                     wb_whilo,
   output logic [DATA_W-1:0]        wb_hi,
   output logic [DATA_W-1:0]        wb_lo,
   output logic                     wb_llbit_we,
   output logic                     wb_llbit_value,
   output logic [63:0]              retire_cnt,
   output logic [31:0]              bubble_cnt
);

   if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
      $fatal(1, "mem_wb_pipe: NUM_CH must be in 1..4");
   end
   if (STAGE_IDX >= STALL_W) begin : g_bad_stage_idx
      $fatal(1, "mem_wb_pipe: STAGE_IDX must be below STALL_W");
   end

   // Zero-extend so the last stage sees an always-clear "next stage" stall bit.
   logic [STALL_W:0] stall_ext;
   logic             stall_here;
   logic             stall_next;
   logic             unused_stall;

   assign stall_ext    = {1'b0, stall};
   assign stall_here   = stall_ext[STAGE_IDX];
   assign stall_next   = stall_ext[STAGE_IDX+1];
   assign unused_stall = ^stall;

   logic [NUM_CH-1:0] qual;
   logic [NUM_CH-1:0] wreg_res;
   logic [2:0]        n_valid;

   always_comb begin
      qual    = '0;
      n_valid = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         qual[i] = mem_wreg[i] & mem_valid[i] & (mem_wd[i*ADDR_W +: ADDR_W] != '0);
         n_valid = n_valid + 3'(mem_valid[i]);
      end
      // A younger channel writing the same register shadows every older one.
      wreg_res = qual;
      for (int i = 0; i < NUM_CH; i++) begin
         for (int j = i + 1; j < NUM_CH; j++) begin
            if (qual[j] && (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
               wreg_res[i] = 1'b0;
            end
         end
      end
   end

   logic [NUM_CH-1:0]        valid_q, valid_d;
   logic [NUM_CH*ADDR_W-1:0] wd_q, wd_d;
   logic [NUM_CH-1:0]        wreg_q, wreg_d;
   logic [NUM_CH*DATA_W-1:0] wdata_q, wdata_d;
   logic                     whilo_q, whilo_d;
   logic [DATA_W-1:0]        hi_q, hi_d;
   logic [DATA_W-1:0]        lo_q, lo_d;
   logic                     llbit_we_q, llbit_we_d;
   logic                     llbit_value_q, llbit_value_d;
   logic [63:0]              retire_cnt_q, retire_cnt_d;
   logic [31:0]              bubble_cnt_q, bubble_cnt_d;

   logic do_clear;
   logic do_bubble;
   logic do_capture;

   assign do_bubble  = ~flush & stall_here & ~stall_next;
   assign do_clear   = flush | do_bubble;
   assign do_capture = ~flush & ~stall_here;

   always_comb begin
      // Default is hold.
      valid_d       = valid_q;
      wd_d          = wd_q;
      wreg_d        = wreg_q;
      wdata_d       = wdata_q;
      whilo_d       = whilo_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      llbit_we_d    = llbit_we_q;
      llbit_value_d = llbit_value_q;
      retire_cnt_d  = retire_cnt_q;
      bubble_cnt_d  = bubble_cnt_q;

      if (do_clear) begin
         valid_d       = '0;
         wd_d          = '0;
         wreg_d        = '0;
         wdata_d       = '0;
         whilo_d       = 1'b0;
         hi_d          = '0;
         lo_d          = '0;
         llbit_we_d    = 1'b0;
         llbit_value_d = 1'b0;
      end else if (do_capture) begin
         valid_d       = mem_valid;
         wd_d          = mem_wd;
         wreg_d        = wreg_res;
         wdata_d       = mem_wdata;
         whilo_d       = mem_whilo;
         hi_d          = mem_hi;
         lo_d          = mem_lo;
         llbit_we_d    = mem_llbit_we;
         llbit_value_d = mem_llbit_value;
         retire_cnt_d  = retire_cnt_q + 64'(n_valid);
      end

      if (do_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= '0;
         wd_q          <= '0;
         wreg_q        <= '0;
         wdata_q       <= '0;
         whilo_q       <= 1'b0;
         hi_q          <= '0;
         lo_q          <= '0;
         llbit_we_q    <= 1'b0;
         llbit_value_q <= 1'b0;
         retire_cnt_q  <= '0;
         bubble_cnt_q  <= '0;
      end else begin
         valid_q       <= valid_d;
         wd_q          <= wd_d;
         wreg_q        <= wreg_d;
         wdata_q       <= wdata_d;
         whilo_q       <= whilo_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         llbit_we_q    <= llbit_we_d;
         llbit_value_q <= llbit_value_d;
         retire_cnt_q  <= retire_cnt_d;
         bubble_cnt_q  <= bubble_cnt_d;
      end
   end

   assign wb_valid       = valid_q;
   assign wb_wd          = wd_q;
   assign wb_wreg        = wreg_q;
   assign wb_wdata       = wdata_q;
   assign wb_whilo       = whilo_q;
   assign wb_hi          = hi_q;
   assign wb_lo          = lo_q;
   assign wb_llbit_we    = llbit_we_q;
   assign wb_llbit_value = llbit_value_q;
   assign retire_cnt     = retire_cnt_q;
   assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: self-checking bench for mem_wb_pipe (default parameters).
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the stage kept in this file.
module tb_mem_wb_pipe;

   localparam int NC = 2;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int SW = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [SW-1:0]     stall;
   logic              flush;
   logic [NC-1:0]     mem_valid;
   logic [NC*AW-1:0]  mem_wd;
   logic [NC-1:0]     mem_wreg;
   logic [NC*DW-1:0]  mem_wdata;
   logic              mem_whilo;
   logic [DW-1:0]     mem_hi;
   logic [DW-1:0]     mem_lo;
   logic              mem_llbit_we;
   logic              mem_llbit_value;
   logic [NC-1:0]     wb_valid;
   logic [NC*AW-1:0]  wb_wd;
   logic [NC-1:0]     wb_wreg;
   logic [NC*DW-1:0]  wb_wdata;
   logic              wb_whilo;
   logic [DW-1:0]     wb_hi;
   logic [DW-1:0]     wb_lo;
   logic              wb_llbit_we;
   logic              wb_llbit_value;
   logic [63:0]       retire_cnt;
   logic [31:0]       bubble_cnt;

   mem_wb_pipe dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .mem_valid       (mem_valid),
      .mem_wd          (mem_wd),
      .mem_wreg        (mem_wreg),
      .mem_wdata       (mem_wdata),
      .mem_whilo       (mem_whilo),
      .mem_hi          (mem_hi),
      .mem_lo          (mem_lo),
      .mem_llbit_we    (mem_llbit_we),
      .mem_llbit_value (mem_llbit_value),
      .wb_valid        (wb_valid),
      .wb_wd           (wb_wd),
      .wb_wreg         (wb_wreg),
      .wb_wdata        (wb_wdata),
      .wb_whilo        (wb_whilo),
      .wb_hi           (wb_hi),
      .wb_lo           (wb_lo),
      .wb_llbit_we     (wb_llbit_we),
      .wb_llbit_value  (wb_llbit_value),
      .retire_cnt      (retire_cnt),
      .bubble_cnt      (bubble_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   // Reference model state: what the WB side should show after each edge.
   logic [NC-1:0]    m_valid;
   logic [NC*AW-1:0] m_wd;
   logic [NC-1:0]    m_wreg;
   logic [NC*DW-1:0] m_wdata;
   logic             m_whilo;
   logic [DW-1:0]    m_hi;
   logic [DW-1:0]    m_lo;
   logic             m_llwe;
   logic             m_llv;
   logic [63:0]      m_ret;
   logic [31:0]      m_bub;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear_payload();
      m_valid = '0; m_wd = '0; m_wreg = '0; m_wdata = '0;
      m_whilo = 1'b0; m_hi = '0; m_lo = '0; m_llwe = 1'b0; m_llv = 1'b0;
   endtask

   // One clock edge of the stage, from the rules: rst > flush > bubble > advance > hold.
   task automatic model_edge();
      int last_writer [32];
      int addr;
      if (rst) begin
         model_clear_payload();
         m_ret = '0;
         m_bub = '0;
      end else if (flush) begin
         model_clear_payload();
      end else if (stall[4] && !stall[5]) begin
         model_clear_payload();
         if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      end else if (!stall[4]) begin
         for (int a = 0; a < 32; a++) last_writer[a] = -1;
         for (int i = 0; i < NC; i++) begin
            addr = int'(mem_wd[i*AW +: AW]);
            if (mem_valid[i] && mem_wreg[i] && addr != 0) last_writer[addr] = i;
         end
         m_wreg = '0;
         for (int i = 0; i < NC; i++) begin
            addr = int'(mem_wd[i*AW +: AW]);
            if (mem_valid[i] && mem_wreg[i] && addr != 0 && last_writer[addr] == i)
               m_wreg[i] = 1'b1;
         end
         m_valid = mem_valid; m_wd = mem_wd; m_wdata = mem_wdata;
         m_whilo = mem_whilo; m_hi = mem_hi; m_lo = mem_lo;
         m_llwe  = mem_llbit_we; m_llv = mem_llbit_value;
         m_ret   = m_ret + 64'($countones(mem_valid));
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"},  64'(wb_valid),       64'(m_valid));
      check({tag, ".wd"},     64'(wb_wd),          64'(m_wd));
      check({tag, ".wreg"},   64'(wb_wreg),        64'(m_wreg));
      check({tag, ".wdata"},  64'(wb_wdata),       64'(m_wdata));
      check({tag, ".whilo"},  64'(wb_whilo),       64'(m_whilo));
      check({tag, ".hi"},     64'(wb_hi),          64'(m_hi));
      check({tag, ".lo"},     64'(wb_lo),          64'(m_lo));
      check({tag, ".llwe"},   64'(wb_llbit_we),    64'(m_llwe));
      check({tag, ".llv"},    64'(wb_llbit_value), 64'(m_llv));
      check({tag, ".retire"}, retire_cnt,          m_ret);
      check({tag, ".bubble"}, 64'(bubble_cnt),     64'(m_bub));
   endtask

   // Inputs are driven 1 time unit after a rising edge; outputs sampled there too.
   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic rand_payload(input int max_wd);
      mem_valid       = NC'($urandom);
      mem_wreg        = NC'($urandom);
      for (int i = 0; i < NC; i++) mem_wd[i*AW +: AW] = AW'($urandom_range(0, max_wd));
      mem_wdata       = {$urandom, $urandom};
      mem_whilo       = 1'($urandom);
      mem_hi          = $urandom;
      mem_lo          = $urandom;
      mem_llbit_we    = 1'($urandom);
      mem_llbit_value = 1'($urandom);
   endtask

   initial begin
      m_ret = '0;
      m_bub = '0;
      model_clear_payload();
      rst = 1'b1; flush = 1'b0; stall = '0;
      rand_payload(31);
      #1;

      // T1: reset with random inputs, including a stall and a flush
      step("t1a");
      stall = 6'b010000; flush = 1'b1; rand_payload(31);
      step("t1b");
      check("t1.retire0", retire_cnt, 64'd0);
      check("t1.bubble0", 64'(bubble_cnt), 64'd0);
      check("t1.valid0", 64'(wb_valid), 64'd0);

      // T2: plain advance of two independent writes
      rst = 1'b0; flush = 1'b0; stall = '0;
      mem_valid = 2'b11; mem_wreg = 2'b11;
      mem_wd = {5'd4, 5'd3}; mem_wdata = {32'h22, 32'h11};
      mem_whilo = 1'b1; mem_hi = 32'hAAAA_0001; mem_lo = 32'h5555_0002;
      mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
      step("t2");
      check("t2.wreg11", 64'(wb_wreg), 64'd3);
      check("t2.wdata", 64'(wb_wdata), {32'h22, 32'h11});
      check("t2.retire2", retire_cnt, 64'd2);

      // T3: same-beat conflict, then an r0 write
      mem_wd = {5'd7, 5'd7};
      step("t3a");
      check("t3.conflict", 64'(wb_wreg), 64'd2);
      mem_wd = {5'd5, 5'd0};
      step("t3b");
      check("t3.r0", 64'(wb_wreg), 64'd2);
      check("t3.retire6", retire_cnt, 64'd6);

      // T4: hold for three cycles with changing inputs, then one bubble
      stall = 6'b110000;
      for (int k = 0; k < 3; k++) begin
         rand_payload(31);
         step("t4hold");
         check("t4.hold_wd", 64'(wb_wd), 64'({5'd5, 5'd0}));
      end
      stall = 6'b010000;
      step("t4bub");
      check("t4.bubble1", 64'(bubble_cnt), 64'd1);
      check("t4.bub_valid", 64'(wb_valid), 64'd0);

      // T5: flush wins over a hold stall while valid data is presented
      stall = '0; mem_valid = 2'b11; mem_wreg = 2'b11; mem_wd = {5'd9, 5'd8};
      step("t5adv");
      stall = 6'b110000; flush = 1'b1; rand_payload(31); mem_valid = 2'b11;
      step("t5flush");
      check("t5.valid", 64'(wb_valid), 64'd0);
      check("t5.retire", retire_cnt, 64'd8);
      flush = 1'b0;

      // T6: counter limits; preload the counters through their next-state values
      stall = 6'b110000;
      force dut.retire_cnt_d = 64'hFFFF_FFFF_FFFF_FFFF;
      force dut.bubble_cnt_d = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.retire_cnt_d;
      release dut.bubble_cnt_d;
      m_ret = 64'hFFFF_FFFF_FFFF_FFFF;
      m_bub = 32'hFFFF_FFFF;
      #1;
      check_all("t6pre");
      stall = '0; mem_valid = 2'b11;
      step("t6wrap");
      check("t6.retire_wrap", retire_cnt, 64'd1);
      stall = 6'b010000;
      step("t6sat");
      check("t6.bubble_sat", 64'(bubble_cnt), 64'hFFFF_FFFF);

      // Randomized traffic from a clean reset
      rst = 1'b1; flush = 1'b0; stall = '0;
      step("rnd_rst");
      for (int k = 0; k < 400; k++) begin
         rst   = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       stall = 6'b000000;
            1:       stall = 6'b010000;
            2:       stall = 6'b110000;
            default: stall = 6'($urandom);
         endcase
         rand_payload(3);
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
